// File: rtl/datamemory_split.sv
// datamemory_split
//   Byte-addressable 32-bit data memory. A word-crossing access is split into
//   two single-word accesses, or it faults when ALLOW_MISALIGNED = 0.
//   Requests are handled one at a time by a small FSM: IDLE -> ACC1 [-> ACC2] -> RESP.
//
// Ports
//   clk        : clock. All state changes on the rising edge.
//   rst        : asynchronous, active-high reset. Memory contents are kept.
//   ReqValid   : a request is present.
//   ReqReady   : the block can accept a request (high only in IDLE).
//   Address    : byte address, little-endian.
//   DataWr     : store data. The low bytes are used according to the size.
//   DMCtrl     : 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
//   DMWr       : 1 = store, 0 = load.
//   RspValid   : one-cycle response pulse, in RESP.
//   DataRd     : load result, extended according to DMCtrl. It is 0 for stores
//                and 0 outside RESP.
//   Fault      : the request was rejected. Qualified by RspValid.
//   dbg_state  : current FSM state (0 IDLE, 1 ACC1, 2 ACC2, 3 RESP).
//
// Handshake: a request transfers on a rising edge where ReqValid && ReqReady.
// All request fields are captured at that edge. After that edge the inputs
// are ignored until the block is back in IDLE. Exactly one RspValid pulse
// follows each accepted request, unless reset intervenes.

module datamemory_split #(
   parameter int DEPTH_WORDS      = 256,
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ReqValid,
   output logic        ReqReady,
   input  logic [31:0] Address,
   input  logic [31:0] DataWr,
   input  logic [2:0]  DMCtrl,
   input  logic        DMWr,
   output logic        RspValid,
   output logic [31:0] DataRd,
   output logic        Fault,
   output logic [1:0]  dbg_state
);

   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam logic [32:0] MEM_BYTES = 33'(4 * DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE = 2'd0, ACC1 = 2'd1, ACC2 = 2'd2, RESP = 2'd3} state_t;

   state_t        state;
   logic [AW+1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [2:0]    ctrl_q;
   logic          wr_q;
   logic          cross_q;
   logic [31:0]   hold_lo;

   logic [31:0]   mem [DEPTH_WORDS];

   // ---------------- acceptance-time decode (from live inputs) ----------------
   logic [1:0] size_m1;
   logic       ctrl_bad, range_bad, align_bad, req_fault, req_cross;

   always_comb begin
      case (DMCtrl[1:0])
         2'b00:   size_m1 = 2'd0;
         2'b01:   size_m1 = 2'd1;
         default: size_m1 = 2'd3;
      endcase
      ctrl_bad  = (DMCtrl == 3'b011) || (DMCtrl == 3'b110) || (DMCtrl == 3'b111);
      // 33-bit sum so that addresses near 2^32 cannot wrap back into range.
      range_bad = (({1'b0, Address} + {31'b0, size_m1}) >= MEM_BYTES);
      align_bad = !ALLOW_MISALIGNED && ((Address[1:0] & size_m1) != 2'b00);
      req_fault = ctrl_bad || range_bad || align_bad;
      req_cross = (({1'b0, Address[1:0]} + {1'b0, size_m1}) > 3'd3);
   end

   // ---------------- access-time datapath (from latched request) --------------
   logic [AW-1:0] word_lo, word_hi;
   logic [3:0]    be_base;
   logic [7:0]    wide_be;
   logic [63:0]   wide_wd;
   logic [63:0]   window;
   logic [31:0]   aligned;
   logic [31:0]   load_val;

   assign word_lo = addr_q[AW+1:2];
   assign word_hi = word_lo + {{(AW-1){1'b0}}, 1'b1};

   always_comb begin
      case (ctrl_q[1:0])
         2'b00:   be_base = 4'b0001;
         2'b01:   be_base = 4'b0011;
         default: be_base = 4'b1111;
      endcase
      // Byte lanes across the two-word window. Lanes 0-3 go to word_lo and
      // lanes 4-7 go to word_hi.
      wide_be = {4'b0000, be_base} << addr_q[1:0];
      wide_wd = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
      // In ACC2 the low word comes from the holding register and the high word
      // comes from memory. In ACC1 only the low word matters.
      window  = (state == ACC2) ? {mem[word_hi], hold_lo} : {32'b0, mem[word_lo]};
      aligned = 32'(window >> {addr_q[1:0], 3'b000});
      case (ctrl_q)
         3'b000:  load_val = {{24{aligned[7]}}, aligned[7:0]};
         3'b001:  load_val = {{16{aligned[15]}}, aligned[15:0]};
         3'b100:  load_val = {24'b0, aligned[7:0]};
         3'b101:  load_val = {16'b0, aligned[15:0]};
         default: load_val = aligned;
      endcase
   end

   assign ReqReady  = (state == IDLE);
   assign dbg_state = state;

   // ---------------- control FSM with registered outputs ----------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         ctrl_q   <= '0;
         wr_q     <= 1'b0;
         cross_q  <= 1'b0;
         hold_lo  <= '0;
         RspValid <= 1'b0;
         DataRd   <= '0;
         Fault    <= 1'b0;
      end else begin
         RspValid <= 1'b0;
         DataRd   <= '0;
         Fault    <= 1'b0;
         case (state)
            IDLE: begin
               if (ReqValid) begin
                  addr_q  <= Address[AW+1:0];
                  wdata_q <= DataWr;
                  ctrl_q  <= DMCtrl;
                  wr_q    <= DMWr;
                  cross_q <= req_cross && !req_fault;
                  if (req_fault) begin
                     state    <= RESP;
                     RspValid <= 1'b1;
                     Fault    <= 1'b1;
                  end else begin
                     state <= ACC1;
                  end
               end
            end
            ACC1: begin
               hold_lo <= mem[word_lo];
               if (cross_q) begin
                  state <= ACC2;
               end else begin
                  state    <= RESP;
                  RspValid <= 1'b1;
                  DataRd   <= wr_q ? 32'b0 : load_val;
               end
            end
            ACC2: begin
               state    <= RESP;
               RspValid <= 1'b1;
               DataRd   <= wr_q ? 32'b0 : load_val;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ---------------- storage: per-byte writes, never reset --------------------
   // Faulting requests never reach ACC1/ACC2, so they cannot write. Reset forces
   // IDLE at once, so a store interrupted in ACC2 loses its second word.
   always_ff @(posedge clk) begin
      if (!rst && wr_q) begin
         if (state == ACC1) begin
            for (int i = 0; i < 4; i++)
               if (wide_be[i]) mem[word_lo][8*i +: 8] <= wide_wd[8*i +: 8];
         end else if (state == ACC2) begin
            for (int i = 0; i < 4; i++)
               if (wide_be[4+i]) mem[word_hi][8*i +: 8] <= wide_wd[32+8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_datamemory_split.sv
// tb_datamemory_split
//   Directed bench for datamemory_split. Instance "a" uses the defaults
//   (256 words, misaligned accesses split). Instance "b" has 16 words and
//   faults on misaligned accesses. The two instances share the clock and reset.

module tb_datamemory_split;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        a_valid = 1'b0, a_ready, a_wr = 1'b0, a_rsp, a_fault;
   logic [31:0] a_addr = '0, a_wd = '0, a_rd;
   logic [2:0]  a_ctrl = '0;
   logic [1:0]  a_dbg;

   logic        b_valid = 1'b0, b_ready, b_wr = 1'b0, b_rsp, b_fault;
   logic [31:0] b_addr = '0, b_wd = '0, b_rd;
   logic [2:0]  b_ctrl = '0;
   logic [1:0]  b_dbg;

   int tests = 0;
   int fails = 0;

   datamemory_split u_a (
      .clk(clk), .rst(rst), .ReqValid(a_valid), .ReqReady(a_ready),
      .Address(a_addr), .DataWr(a_wd), .DMCtrl(a_ctrl), .DMWr(a_wr),
      .RspValid(a_rsp), .DataRd(a_rd), .Fault(a_fault), .dbg_state(a_dbg)
   );

   datamemory_split #(.DEPTH_WORDS(16), .ALLOW_MISALIGNED(1'b0)) u_b (
      .clk(clk), .rst(rst), .ReqValid(b_valid), .ReqReady(b_ready),
      .Address(b_addr), .DataWr(b_wd), .DMCtrl(b_ctrl), .DMWr(b_wr),
      .RspValid(b_rsp), .DataRd(b_rd), .Fault(b_fault), .dbg_state(b_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- driver ----------------
   // The task is called at a negedge with the selected instance in IDLE. It
   // returns at a negedge, one cycle after the response, with the instance in IDLE.
   task automatic run_req(input bit sel, input string tag, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [2:0] ctrl, input logic wr,
                          input int exp_lat, input logic exp_fault, input logic [31:0] exp_rd);
      int          lat = 0;
      int          low = 0;
      bit          got = 1'b0;
      logic [31:0] rd  = '0;
      logic        f   = 1'b0;
      if (sel) begin b_valid = 1'b1; b_addr = addr; b_wd = wd; b_ctrl = ctrl; b_wr = wr; end
      else     begin a_valid = 1'b1; a_addr = addr; a_wd = wd; a_ctrl = ctrl; a_wr = wr; end
      check({tag, " ready"}, {31'b0, sel ? b_ready : a_ready}, 32'd1);
      @(posedge clk);
      #1;
      // Change every field after acceptance. The DUT must use the latched copy.
      if (sel) begin
         b_valid = 1'b0; b_addr = $urandom; b_wd = $urandom;
         b_ctrl = 3'($urandom_range(0, 7)); b_wr = ~wr;
      end else begin
         a_valid = 1'b0; a_addr = $urandom; a_wd = $urandom;
         a_ctrl = 3'($urandom_range(0, 7)); a_wr = ~wr;
      end
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         lat++;
         if (!(sel ? b_ready : a_ready)) low++;
         if (sel ? b_rsp : a_rsp) begin
            got = 1'b1;
            rd  = sel ? b_rd : a_rd;
            f   = sel ? b_fault : a_fault;
         end
      end
      check({tag, " rsp seen"}, {31'b0, got}, 32'd1);
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " ready low cycles"}, 32'(low), 32'(exp_lat));
      check({tag, " fault"}, {31'b0, f}, {31'b0, exp_fault});
      check({tag, " data"}, rd, exp_rd);
      @(negedge clk);
      check({tag, " single pulse"}, {31'b0, sel ? b_rsp : a_rsp}, 32'd0);
      check({tag, " ready again"}, {31'b0, sel ? b_ready : a_ready}, 32'd1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n_rsp;

      // Reset state
      @(negedge clk);
      check("rst a RspValid", {31'b0, a_rsp}, 32'd0);
      check("rst a Fault", {31'b0, a_fault}, 32'd0);
      check("rst a DataRd", a_rd, 32'd0);
      check("rst a state", {30'b0, a_dbg}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post-rst a ReqReady", {31'b0, a_ready}, 32'd1);
      check("post-rst b ReqReady", {31'b0, b_ready}, 32'd1);

      // Byte store followed by signed and unsigned loads
      run_req(0, "sb A=0",  32'd0, 32'hf00000f8, 3'b000, 1'b1, 2, 1'b0, 32'h0);
      run_req(0, "lb A=0",  32'd0, 32'h0,        3'b000, 1'b0, 2, 1'b0, 32'hfffffff8);
      run_req(0, "lbu A=0", 32'd0, 32'h0,        3'b100, 1'b0, 2, 1'b0, 32'h000000f8);

      // Misaligned half inside a word
      run_req(0, "sh A=1",  32'd1, 32'h0000fffe, 3'b001, 1'b1, 2, 1'b0, 32'h0);
      run_req(0, "lh A=1",  32'd1, 32'h0,        3'b001, 1'b0, 2, 1'b0, 32'hfffffffe);
      run_req(0, "lhu A=1", 32'd1, 32'h0,        3'b101, 1'b0, 2, 1'b0, 32'h0000fffe);
      run_req(0, "lbu A=0 kept", 32'd0, 32'h0,   3'b100, 1'b0, 2, 1'b0, 32'h000000f8);

      // Word store that crosses a word boundary: bytes 3..6 = 01 00 00 80
      run_req(0, "sw A=3",  32'd3, 32'h80000001, 3'b010, 1'b1, 3, 1'b0, 32'h0);
      run_req(0, "lw A=3",  32'd3, 32'h0,        3'b010, 1'b0, 3, 1'b0, 32'h80000001);
      run_req(0, "lbu A=3", 32'd3, 32'h0,        3'b100, 1'b0, 2, 1'b0, 32'h00000001);
      run_req(0, "lbu A=6", 32'd6, 32'h0,        3'b100, 1'b0, 2, 1'b0, 32'h00000080);
      run_req(0, "lhu A=3", 32'd3, 32'h0,        3'b101, 1'b0, 3, 1'b0, 32'h00000001);
      run_req(0, "lh A=5",  32'd5, 32'h0,        3'b001, 1'b0, 2, 1'b0, 32'hffff8000);

      // Faults
      run_req(0, "ctrl011 A=0", 32'd0, 32'h0, 3'b011, 1'b0, 1, 1'b1, 32'h0);
      run_req(0, "sw ctrl111 A=0", 32'd0, 32'h12345678, 3'b111, 1'b1, 1, 1'b1, 32'h0);
      run_req(0, "lbu A=0 after fault", 32'd0, 32'h0, 3'b100, 1'b0, 2, 1'b0, 32'h000000f8);
      run_req(0, "sw last word", 32'h3fc, 32'h12345678, 3'b010, 1'b1, 2, 1'b0, 32'h0);
      run_req(0, "lw oob", 32'h3fe, 32'h0, 3'b010, 1'b0, 1, 1'b1, 32'h0);
      run_req(0, "sw oob", 32'h3fe, 32'hdeadbeef, 3'b010, 1'b1, 1, 1'b1, 32'h0);
      run_req(0, "lw last word kept", 32'h3fc, 32'h0, 3'b010, 1'b0, 2, 1'b0, 32'h12345678);

      // Misaligned accesses fault on instance b
      run_req(1, "b lh A=1", 32'd1, 32'h0, 3'b001, 1'b0, 1, 1'b1, 32'h0);
      run_req(1, "b lw A=2", 32'd2, 32'h0, 3'b010, 1'b0, 1, 1'b1, 32'h0);
      run_req(1, "b sw A=4", 32'd4, 32'hcafef00d, 3'b010, 1'b1, 2, 1'b0, 32'h0);
      run_req(1, "b lw A=4", 32'd4, 32'h0, 3'b010, 1'b0, 2, 1'b0, 32'hcafef00d);
      run_req(1, "b lbu A=5", 32'd5, 32'h0, 3'b100, 1'b0, 2, 1'b0, 32'h000000f0);
      run_req(1, "b lb A=7", 32'd7, 32'h0, 3'b000, 1'b0, 2, 1'b0, 32'hffffffca);

      // Reset during ACC2 of a crossing store
      run_req(0, "sw A=0 zero", 32'd0, 32'h0, 3'b010, 1'b1, 2, 1'b0, 32'h0);
      run_req(0, "sw A=4 zero", 32'd4, 32'h0, 3'b010, 1'b1, 2, 1'b0, 32'h0);
      a_valid = 1'b1; a_addr = 32'd3; a_wd = 32'haabbccdd; a_ctrl = 3'b010; a_wr = 1'b1;
      @(posedge clk);
      #1;
      a_valid = 1'b0;
      @(negedge clk);
      check("rst-acc2 in ACC1", {30'b0, a_dbg}, 32'd1);
      @(negedge clk);
      check("rst-acc2 in ACC2", {30'b0, a_dbg}, 32'd2);
      rst = 1'b1;
      #1;
      check("rst-acc2 state idle", {30'b0, a_dbg}, 32'd0);
      check("rst-acc2 ready", {31'b0, a_ready}, 32'd1);
      check("rst-acc2 RspValid", {31'b0, a_rsp}, 32'd0);
      check("rst-acc2 DataRd", a_rd, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      n_rsp = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (a_rsp) n_rsp++;
      end
      check("rst-acc2 no response", 32'(n_rsp), 32'd0);
      run_req(0, "lbu A=3 after rst", 32'd3, 32'h0, 3'b100, 1'b0, 2, 1'b0, 32'h000000dd);
      run_req(0, "lbu A=4 after rst", 32'd4, 32'h0, 3'b100, 1'b0, 2, 1'b0, 32'h00000000);
      run_req(0, "lbu A=5 after rst", 32'd5, 32'h0, 3'b100, 1'b0, 2, 1'b0, 32'h00000000);
      run_req(0, "lbu A=6 after rst", 32'd6, 32'h0, 3'b100, 1'b0, 2, 1'b0, 32'h00000000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
